rob_data_mem: RTL and testbench

Single-ported data memory responder on the commit side of the reorder buffer. It accepts committed stores (ROBMWE) and committed loads (ROBMRegWrite) one at a time and completes each after a fixed latency. It throttles the ROB through CacheReady and returns load data tagged with the ROB entry and destination register for the register-file writeback and reservation-station broadcast paths.

---
 rtl/rob_data_mem.sv | 192 +++++++++++++++++++
 tb/tb_rob_data_mem.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_data_mem.sv
// Commit-side data memory responder for the reorder buffer: one store or load
// in flight at a time, completed a fixed LAT edges after it is accepted.
module rob_data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int LAT   = 3
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        ROBMWE,
  input  logic [31:0] ROBMWA,
  input  logic [31:0] ROBMWD,
  input  logic        ROBMRegWrite,
  input  logic [31:0] ROBMRA,
  input  logic [3:0]  ROBMTag,
  input  logic [4:0]  ROBMWriteReg,
  output logic        CacheReady,
  output logic        MemRegWrite,
  output logic [3:0]  MemTag,
  output logic [4:0]  MemWriteReg,
  output logic [31:0] MemResult,
  output logic        MemConflict
);

  localparam int CW = $clog2(LAT + 1);
  localparam bit MULTI = (LAT > 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic          pend_q, pend_d;
  logic          pst_q, pst_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    tag_q, tag_d;
  logic [4:0]    wreg_q, wreg_d;
  logic          mrw_q, mrw_d;
  logic [3:0]    mtag_q, mtag_d;
  logic [4:0]    mreg_q, mreg_d;
  logic [31:0]   mres_q, mres_d;
  logic          mconf_q, mconf_d;

  logic [31:0]   mem [DEPTH];
  logic          accept_s;
  logic          done_s;
  logic          mem_we_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  assign accept_s = rdy_q & (ROBMWE | ROBMRegWrite);
  // The pending op completes on the edge where the down-counter sits at zero.
  assign done_s   = pend_q & (cnt_q == '0);
  assign mem_we_s = done_s & pst_q;
  assign rdata_s  = mem[idx_q];
  assign unused_s = ^{ROBMWA[31:AW+2], ROBMWA[1:0], ROBMRA[31:AW+2], ROBMRA[1:0]};

  // Next-state logic: FSM, pending-op capture and response generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b1;
    pend_d  = pend_q;
    pst_d   = pst_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    tag_d   = tag_q;
    wreg_d  = wreg_q;
    mrw_d   = 1'b0;
    mtag_d  = mtag_q;
    mreg_d  = mreg_q;
    mres_d  = mres_q;
    mconf_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s && MULTI) begin
          state_d = BUSY;
          cnt_d   = CW'(LAT - 1);
          rdy_d   = 1'b0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          rdy_d   = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          if (accept_s) begin
            state_d = BUSY;
            cnt_d   = CW'(LAT - 1);
            rdy_d   = 1'b0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            rdy_d   = 1'b1;
          end
        end else begin
          state_d = BUSY;
          cnt_d   = cnt_q - CW'(1);
          rdy_d   = (cnt_q == CW'(1));
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rdy_d   = 1'b1;
      end
    endcase

    if (done_s) begin
      pend_d = 1'b0;
      if (!pst_q) begin
        mrw_d  = 1'b1;
        mtag_d = tag_q;
        mreg_d = wreg_q;
        mres_d = rdata_s;
      end else begin
        mrw_d  = 1'b0;
      end
    end else begin
      pend_d = pend_q;
    end

    // A simultaneous load is dropped in favour of the store.
    if (accept_s) begin
      pend_d  = 1'b1;
      pst_d   = ROBMWE;
      idx_d   = ROBMWE ? ROBMWA[AW+1:2] : ROBMRA[AW+1:2];
      wdata_d = ROBMWD;
      tag_d   = ROBMTag;
      wreg_d  = ROBMWriteReg;
      mconf_d = ROBMWE & ROBMRegWrite;
    end else begin
      mconf_d = 1'b0;
    end
  end

  // State and registered outputs; reset abandons any in-flight op.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      pend_q  <= 1'b0;
      pst_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      tag_q   <= 4'h0;
      wreg_q  <= 5'h0;
      mrw_q   <= 1'b0;
      mtag_q  <= 4'h0;
      mreg_q  <= 5'h0;
      mres_q  <= 32'h0;
      mconf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      pend_q  <= pend_d;
      pst_q   <= pst_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
      wreg_q  <= wreg_d;
      mrw_q   <= mrw_d;
      mtag_q  <= mtag_d;
      mreg_q  <= mreg_d;
      mres_q  <= mres_d;
      mconf_q <= mconf_d;
    end
  end

  // Storage array: no reset, written only when a store completes.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign CacheReady  = rdy_q;
  assign MemRegWrite = mrw_q;
  assign MemTag      = mtag_q;
  assign MemWriteReg = mreg_q;
  assign MemResult   = mres_q;
  assign MemConflict = mconf_q;

endmodule

// File: tb/tb_rob_data_mem.sv
// Self-checking bench for rob_data_mem: directed vector table, multi-cycle
// corner sequences, and a randomized run against a transaction-level model.
module tb_rob_data_mem;
  localparam int LAT = 3;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        ROBMWE, ROBMRegWrite;
  logic [31:0] ROBMWA, ROBMWD, ROBMRA;
  logic [3:0]  ROBMTag;
  logic [4:0]  ROBMWriteReg;
  logic        CacheReady, MemRegWrite, MemConflict;
  logic [3:0]  MemTag;
  logic [4:0]  MemWriteReg;
  logic [31:0] MemResult;

  int tests = 0;
  int fails = 0;

  rob_data_mem #(.DEPTH(256), .AW(8), .LAT(LAT)) dut (
    .CLK(CLK), .reset(reset),
    .ROBMWE(ROBMWE), .ROBMWA(ROBMWA), .ROBMWD(ROBMWD),
    .ROBMRegWrite(ROBMRegWrite), .ROBMRA(ROBMRA), .ROBMTag(ROBMTag),
    .ROBMWriteReg(ROBMWriteReg), .CacheReady(CacheReady),
    .MemRegWrite(MemRegWrite), .MemTag(MemTag), .MemWriteReg(MemWriteReg),
    .MemResult(MemResult), .MemConflict(MemConflict)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        re;
    logic [31:0] ra;
    logic [3:0]  tag;
    logic [4:0]  wreg;
    logic        exp_conf;
    logic        exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in;
    ROBMWE = 1'b0; ROBMWA = 32'h0; ROBMWD = 32'h0;
    ROBMRegWrite = 1'b0; ROBMRA = 32'h0; ROBMTag = 4'h0; ROBMWriteReg = 5'h0;
  endtask

  task automatic drive(input vec_t v);
    ROBMWE = v.we; ROBMWA = v.wa; ROBMWD = v.wd;
    ROBMRegWrite = v.re; ROBMRA = v.ra; ROBMTag = v.tag; ROBMWriteReg = v.wreg;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!CacheReady && n < 20) begin
      tick;
      n++;
    end
    check("wait_ready", CacheReady, 1'b1);
  endtask

  // One full transaction: accept, busy window, completion, pulse end.
  task automatic run_op(input vec_t v);
    wait_ready;
    drive(v);
    tick;
    idle_in;
    check("conflict", MemConflict, v.exp_conf);
    check("busy_ready", CacheReady, 1'b0);
    for (int i = 1; i < LAT; i++) begin
      tick;
      check("no_early_resp", MemRegWrite, 1'b0);
      check("conflict_once", MemConflict, 1'b0);
      check("ready_window", CacheReady, (i == LAT - 1));
    end
    tick;
    check("resp_valid", MemRegWrite, v.exp_resp);
    if (v.exp_resp) begin
      check("resp_data", MemResult, v.exp_data);
      check("resp_tag", MemTag, v.tag);
      check("resp_reg", MemWriteReg, v.wreg);
    end
    tick;
    check("resp_pulse", MemRegWrite, 1'b0);
    if (v.exp_resp) begin
      check("hold_data", MemResult, v.exp_data);
      check("hold_tag", MemTag, v.tag);
    end
  endtask

  function automatic vec_t st(input logic [31:0] a, input logic [31:0] d);
    st = '{1'b1, a, d, 1'b0, 32'h0, 4'h0, 5'h0, 1'b0, 1'b0, 32'h0};
  endfunction

  function automatic vec_t ld(input logic [31:0] a, input logic [3:0] t,
                              input logic [4:0] r, input logic [31:0] e);
    ld = '{1'b0, 32'h0, 32'h0, 1'b1, a, t, r, 1'b0, 1'b1, e};
  endfunction

  vec_t tbl[7];

  logic [31:0] mem_m [256];
  bit          known_m [256];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in;
    tbl[0] = st(32'h0000_0010, 32'hDEADBEEF);
    tbl[1] = ld(32'h0000_0010, 4'd5, 5'd9, 32'hDEADBEEF);
    tbl[2] = st(32'h0000_0400, 32'h11223344);
    tbl[3] = ld(32'h0000_0002, 4'd1, 5'd2, 32'h11223344);
    tbl[4] = '{1'b1, 32'h20, 32'hA5A5A5A5, 1'b1, 32'h20, 4'd6, 5'd7, 1'b1, 1'b0, 32'h0};
    tbl[5] = ld(32'h0000_0020, 4'd15, 5'd31, 32'hA5A5A5A5);
    tbl[6] = ld(32'hFFFF_FC12, 4'd3, 5'd17, 32'hDEADBEEF);

    // Reset values
    tick; tick;
    check("rst_ready", CacheReady, 1'b0);
    check("rst_mrw", MemRegWrite, 1'b0);
    check("rst_conf", MemConflict, 1'b0);
    check("rst_tag", MemTag, 4'h0);
    check("rst_reg", MemWriteReg, 5'h0);
    check("rst_res", MemResult, 32'h0);
    reset = 1'b1;
    tick;
    check("ready_after_rst", CacheReady, 1'b1);
    check("idle_mrw", MemRegWrite, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("idle_mrw_hold", MemRegWrite, 1'b0);
      check("idle_ready_hold", CacheReady, 1'b1);
    end

    for (int i = 0; i < 7; i++) run_op(tbl[i]);

    // Back-to-back: load accepted on the store's completion edge
    wait_ready;
    drive(st(32'h0000_01F0, 32'h5555AAAA));
    tick;
    idle_in;
    repeat (LAT - 1) tick;
    check("b2b_ready", CacheReady, 1'b1);
    drive(ld(32'h0000_01F0, 4'd7, 5'd3, 32'h0));
    tick;
    idle_in;
    check("b2b_busy", CacheReady, 1'b0);
    repeat (LAT - 1) tick;
    check("b2b_no_early", MemRegWrite, 1'b0);
    tick;
    check("b2b_valid", MemRegWrite, 1'b1);
    check("b2b_data", MemResult, 32'h5555AAAA);
    check("b2b_tag", MemTag, 4'd7);
    tick;

    // Busy drop: load issued while CacheReady is low is ignored
    wait_ready;
    drive(st(32'h0000_0080, 32'hCAFEF00D));
    tick;
    drive(ld(32'h0000_0080, 4'd2, 5'd6, 32'h0));
    tick;
    idle_in;
    check("drop_busy", CacheReady, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("drop_no_resp", MemRegWrite, 1'b0);
    end
    run_op(ld(32'h0000_0080, 4'd4, 5'd5, 32'hCAFEF00D));

    // Reset during an in-flight store
    run_op(st(32'h0000_0040, 32'h1));
    run_op(ld(32'h0000_0040, 4'hA, 5'h1F, 32'h1));
    wait_ready;
    drive(st(32'h0000_0040, 32'h77));
    tick;
    idle_in;
    tick;
    reset = 1'b0;
    #1;
    check("mid_rst_ready", CacheReady, 1'b0);
    check("mid_rst_mrw", MemRegWrite, 1'b0);
    check("mid_rst_conf", MemConflict, 1'b0);
    check("mid_rst_tag", MemTag, 4'h0);
    check("mid_rst_reg", MemWriteReg, 5'h0);
    check("mid_rst_res", MemResult, 32'h0);
    tick; tick;
    check("mid_rst_hold", CacheReady, 1'b0);
    reset = 1'b1;
    tick;
    check("mid_rst_release", CacheReady, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("mid_rst_no_resp", MemRegWrite, 1'b0);
    end
    run_op(ld(32'h0000_0040, 4'h8, 5'h4, 32'h1));

    // Randomized run against a transaction-level model
    begin
      bit          pend_m, pst_m, rdy_m, resp_m, conf_m, eknown_m;
      int          done_m;
      logic [7:0]  pidx_m;
      logic [31:0] pdata_m, edata_m;
      logic [3:0]  ptag_m, etag_m;
      logic [4:0]  preg_m, ereg_m;
      logic        we, re;
      logic [7:0]  widx, ridx;
      for (int i = 0; i < 256; i++) known_m[i] = 1'b0;
      pend_m = 1'b0; rdy_m = 1'b1; done_m = 0;
      pst_m = 1'b0; pidx_m = 8'h0; pdata_m = 32'h0; ptag_m = 4'h0; preg_m = 5'h0;
      edata_m = 32'h0; etag_m = 4'h0; ereg_m = 5'h0; eknown_m = 1'b0;
      for (int e = 0; e < 1500; e++) begin
        we   = ($urandom_range(3, 0) == 0);
        re   = ($urandom_range(2, 0) == 0);
        widx = 8'($urandom_range(15, 0));
        ridx = 8'($urandom_range(15, 0));
        ROBMWE = we;
        ROBMWA = ($urandom & 32'hFFFF_FC03) | (32'(widx) << 2);
        ROBMWD = $urandom;
        ROBMRegWrite = re;
        ROBMRA = ($urandom & 32'hFFFF_FC03) | (32'(ridx) << 2);
        ROBMTag = 4'($urandom);
        ROBMWriteReg = 5'($urandom);

        resp_m = 1'b0;
        conf_m = 1'b0;
        if (pend_m && done_m == e) begin
          pend_m = 1'b0;
          if (pst_m) begin
            mem_m[pidx_m] = pdata_m;
            known_m[pidx_m] = 1'b1;
          end else begin
            resp_m = 1'b1;
            edata_m = mem_m[pidx_m];
            eknown_m = known_m[pidx_m];
            etag_m = ptag_m;
            ereg_m = preg_m;
          end
        end
        if (rdy_m && (we || re)) begin
          pend_m = 1'b1;
          done_m = e + LAT;
          pst_m = we;
          pidx_m = we ? widx : ridx;
          pdata_m = ROBMWD;
          ptag_m = ROBMTag;
          preg_m = ROBMWriteReg;
          conf_m = we && re;
        end
        rdy_m = !pend_m || (done_m - e <= 1);

        tick;
        check("rand_ready", CacheReady, rdy_m);
        check("rand_resp", MemRegWrite, resp_m);
        check("rand_conf", MemConflict, conf_m);
        if (resp_m) begin
          check("rand_tag", MemTag, etag_m);
          check("rand_reg", MemWriteReg, ereg_m);
          if (eknown_m) check("rand_data", MemResult, edata_m);
        end
      end
      idle_in;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
